// File: rtl/quad_pkg.sv
// ============================================================================
// Module : quad_pkg
// Brief  : Shared quadrature state encodings, direction codes and CW ordering.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package quad_pkg;

    typedef logic [1:0] qstate_t;

    // State encoding is {A,B}
    localparam qstate_t Q_S00 = 2'b00;
    localparam qstate_t Q_S10 = 2'b10;
    localparam qstate_t Q_S11 = 2'b11;
    localparam qstate_t Q_S01 = 2'b01;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    function automatic qstate_t q_next_cw(input qstate_t s);
        qstate_t n;
        case (s)
            Q_S00:   n = Q_S10;
            Q_S10:   n = Q_S11;
            Q_S11:   n = Q_S01;
            default: n = Q_S00;
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/quad_sync.sv
// ============================================================================
// Module : quad_sync
// Brief  : Two-flop synchronizer for one phase, plus stability filter when
//          QDEC_FILTER_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module quad_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

`ifdef QDEC_FILTER_EN
    localparam logic [7:0] c_LAST = 8'(FILTER_LEN - 1);

    logic [7:0] r_cnt;
    logic       r_filt;

    // Counter runs only while raw disagrees with the filtered value; a bounce
    // back to the filtered value restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 8'd0;
            r_filt <= 1'b0;
        end else if (r_sync == r_filt) begin
            r_cnt <= 8'd0;
        end else if (r_cnt == c_LAST) begin
            r_cnt  <= 8'd0;
            r_filt <= r_sync;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_sync = r_filt;
`else
    assign o_sync = r_sync;
`endif

endmodule

`default_nettype wire

// File: rtl/quadrature_decoder.sv
// ============================================================================
// Module : quadrature_decoder
// Brief  : Quadrature A/B decoder with signed position, direction, step strobe
//          and sticky illegal-transition flag. QDEC_FILTER_EN adds a filter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FILTER_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    A,
    input  logic                    B,
    input  logic                    clr,
    output logic signed [CNT_W-1:0] count,
    output logic                    dir,
    output logic                    step,
    output logic                    err
);

    // Priming spans the whole input pipeline so the state resting at the pins
    // (not the reset value of the flops) becomes the first accepted state.
`ifdef QDEC_FILTER_EN
    localparam int c_PRIME_CYC = 3 + FILTER_LEN;
`else
    localparam int c_PRIME_CYC = 3;
`endif
    localparam logic [8:0]              c_PRIME_LAST = 9'(c_PRIME_CYC - 1);
    localparam logic signed [CNT_W-1:0] c_ONE        = CNT_W'(1);

    qstate_t    w_cur;
    qstate_t    r_prev;
    logic [8:0] r_prime_cnt;
    logic       r_primed;
    logic       w_cw;
    logic       w_ccw;
    logic       w_bad;

    quad_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_a (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (A),
        .o_sync (w_cur[1])
    );

    quad_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_b (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (B),
        .o_sync (w_cur[0])
    );

    always_comb begin
        w_cw  = r_primed && (q_next_cw(r_prev) == w_cur);
        w_ccw = r_primed && (q_next_cw(w_cur) == r_prev);
        w_bad = r_primed && ((w_cur ^ r_prev) == 2'b11);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev      <= Q_S00;
            r_prime_cnt <= 9'd0;
            r_primed    <= 1'b0;
        end else begin
            r_prev <= w_cur;
            if (!r_primed) begin
                r_prime_cnt <= r_prime_cnt + 9'd1;
                r_primed    <= (r_prime_cnt == c_PRIME_LAST);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            dir   <= DIR_CCW;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= w_cw | w_ccw;
            if (w_cw)
                dir <= DIR_CW;
            else if (w_ccw)
                dir <= DIR_CCW;

            // A step coinciding with clr still strobes but never reaches count.
            if (clr) begin
                count <= '0;
                err   <= 1'b0;
            end else begin
                if (w_cw)
                    count <= count + c_ONE;
                else if (w_ccw)
                    count <= count - c_ONE;
                if (w_bad)
                    err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
// ============================================================================
// Module : tb_quadrature_decoder
// Brief  : Directed self-checking bench; a 16-bit and a 4-bit decoder share
//          the same stimulus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_quadrature_decoder;

`ifdef QDEC_FILTER_EN
    localparam int EXT = 4;
`else
    localparam int EXT = 0;
`endif
    localparam int DWELL = 6 + EXT;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               A   = 1'b1;
    logic               B   = 1'b1;
    logic               clr = 1'b0;
    logic signed [15:0] count16;
    logic signed [3:0]  count4;
    logic               dir16, step16, err16;
    logic               dir4, step4, err4;

    int n_checks = 0;
    int n_fail   = 0;
    int n_steps  = 0;
    int pos      = 2;
    logic [1:0] ring [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always #5 clk = ~clk;

    quadrature_decoder #(.CNT_W(16), .FILTER_LEN(4)) u_dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .clr(clr),
        .count(count16), .dir(dir16), .step(step16), .err(err16)
    );

    quadrature_decoder #(.CNT_W(4), .FILTER_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .A(A), .B(B), .clr(clr),
        .count(count4), .dir(dir4), .step(step4), .err(err4)
    );

    always @(negedge clk) if (step16) n_steps++;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s);
        A = s[1];
        B = s[0];
    endtask

    // Move one position along the ring (+1 CW, -1 CCW, 2 illegal) and dwell.
    task automatic move(input int delta);
        pos = (pos + delta + 4) % 4;
        drive(ring[pos]);
        repeat (DWELL) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset count", int'(count16), 0);
        check("reset step", int'(step16), 0);
        check("reset err", int'(err16), 0);
        check("reset dir", int'(dir16), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rest11 count", int'(count16), 0);
        check("rest11 steps", n_steps, 0);
        check("rest11 err", int'(err16), 0);

        // First CW step with exact latency
        pos = 3;
        drive(ring[pos]);
        repeat (2 + EXT) @(negedge clk);
        check("lat early step", int'(step16), 0);
        @(negedge clk);
        check("lat step", int'(step16), 1);
        @(negedge clk);
        check("lat step drop", int'(step16), 0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) move(1);
        check("cw8 count", int'(count16), 8);
        check("cw8 steps", n_steps, 8);
        check("cw8 dir", int'(dir16), 1);

        for (int i = 0; i < 3; i++) move(-1);
        check("ccw3 count", int'(count16), 5);
        check("ccw3 dir", int'(dir16), 0);
        check("ccw3 count4", int'(count4), 5);

        move(1);
        move(1);
        check("pre-wrap count4", int'(count4), 7);
        move(1);
        check("wrap up count4", int'(count4), -8);
        check("wrap up count16", int'(count16), 8);
        move(-1);
        check("wrap down count4", int'(count4), 7);

        move(2);
        check("illegal err", int'(err16), 1);
        check("illegal count", int'(count16), 7);
        check("illegal dir held", int'(dir16), 0);
        move(1);
        check("post-err count", int'(count16), 8);
        check("post-err err sticky", int'(err16), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr count", int'(count16), 0);
        check("clr err", int'(err16), 0);

        move(-1);
        check("pre-clr-step count", int'(count16), -1);
        pos = (pos + 1) % 4;
        drive(ring[pos]);
        repeat (2 + EXT) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr+step count", int'(count16), 0);
        check("clr+step step", int'(step16), 1);
        check("clr+step dir", int'(dir16), 1);
        check("clr+step count4", int'(count4), 0);
        repeat (4) @(negedge clk);

`ifdef QDEC_FILTER_EN
        begin
            int before;
            before = n_steps;
            A = ~A;
            repeat (2) @(negedge clk);
            A = ~A;
            repeat (15) @(negedge clk);
            check("glitch no step", n_steps - before, 0);
            check("glitch count", int'(count16), 0);
        end
`endif

        move(1);
        check("pre-reset count", int'(count16), 1);
        #1 rst = 1'b1;
        #1;
        check("async reset count", int'(count16), 0);
        check("async reset dir", int'(dir16), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("reprime count", int'(count16), 0);
        check("reprime err", int'(err16), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
